// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory handshake, stall/redirect control
// from the pipeline, and the instruction slot presented to the IF/ID register.
//   imem_req/imem_addr      fetch request pulse and word address (unit -> memory)
//   imem_valid/imem_rdata   one-cycle response strobe and instruction word (memory -> unit)
//   stall                   decode/hazard hold request (pipeline -> unit)
//   redirect/redirect_pc    taken-branch pulse and target (EX/MEM -> unit)
//   ifid_valid/instr/pc_plus4  instruction slot (unit -> IF/ID)
// master: the fetch unit.  slave: memory plus pipeline environment.
interface if_fetch_unit_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_valid;
   logic [DATA_W-1:0] imem_rdata;
   logic              stall;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              ifid_valid;
   logic [DATA_W-1:0] ifid_instr;
   logic [ADDR_W-1:0] ifid_pc_plus4;

   modport master (
      output imem_req, imem_addr, ifid_valid, ifid_instr, ifid_pc_plus4,
      input  imem_valid, imem_rdata, stall, redirect, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, ifid_valid, ifid_instr, ifid_pc_plus4,
      output imem_valid, imem_rdata, stall, redirect, redirect_pc
   );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register. Owns the PC, keeps at
// most one word fetch outstanding, buffers returned words with their PC+4 in
// a small prefetch FIFO and hands one instruction per cycle to IF/ID.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   if_fetch_unit_if.master (memory handshake, stall/redirect, IF/ID slot)
module if_fetch_unit #(
   parameter int unsigned       ADDR_W     = 32,
   parameter int unsigned       DATA_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0,
   parameter int unsigned       FIFO_DEPTH = 2
) (
   input logic             clk,
   input logic             rst,
   if_fetch_unit_if.master bus
);

   localparam int unsigned       PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned       CNT_W    = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] PC_INIT  = {RESET_PC[ADDR_W-1:2], 2'b00};

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_fetch_pc;
   logic              r_discard;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [DATA_W-1:0] r_fifo_instr [FIFO_DEPTH];
   logic [ADDR_W-1:0] r_fifo_pc4   [FIFO_DEPTH];
   logic              r_ifid_valid;
   logic [DATA_W-1:0] r_ifid_instr;
   logic [ADDR_W-1:0] r_ifid_pc4;

   logic              w_not_full;
   logic              w_resp;
   logic              w_push;
   logic              w_pop;
   logic [ADDR_W-1:0] w_pc_plus4;
   logic              w_unused_ok;

   // Redirect overrides both FIFO ports; a response arriving under a pending
   // discard belongs to a squashed path and is never pushed.
   assign w_not_full = (r_count < FULL_CNT);
   assign w_resp     = (r_state == ST_WAIT) && bus.imem_valid;
   assign w_push     = w_resp && !r_discard && !bus.redirect;
   assign w_pop      = !bus.redirect && !bus.stall && (r_count != '0);
   assign w_pc_plus4 = r_fetch_pc + ADDR_W'(4);

   // Request is decoded straight from state so it goes out in the REQ cycle.
   assign bus.imem_req  = (r_state == ST_REQ) && w_not_full && !rst;
   assign bus.imem_addr = r_fetch_pc;

   assign bus.ifid_valid    = r_ifid_valid;
   assign bus.ifid_instr    = r_ifid_instr;
   assign bus.ifid_pc_plus4 = r_ifid_pc4;

   // Target byte offset is dropped: fetches are always word aligned.
   assign w_unused_ok = &{1'b0, bus.redirect_pc[1:0]};

   // Prefetch storage (data only, no reset needed).
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_instr[r_wr_ptr] <= bus.imem_rdata;
         r_fifo_pc4[r_wr_ptr]   <= w_pc_plus4;
      end
   end

   // Fetch FSM, PC, FIFO pointers and IF/ID output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_REQ;
         r_fetch_pc   <= PC_INIT;
         r_discard    <= 1'b0;
         r_rd_ptr     <= '0;
         r_wr_ptr     <= '0;
         r_count      <= '0;
         r_ifid_valid <= 1'b0;
         r_ifid_instr <= '0;
         r_ifid_pc4   <= '0;
      end else if (bus.redirect) begin
         r_rd_ptr     <= '0;
         r_wr_ptr     <= '0;
         r_count      <= '0;
         r_ifid_valid <= 1'b0;
         r_fetch_pc   <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
         // An in-flight request must still be drained; its word is stale.
         if ((r_state == ST_WAIT) && !bus.imem_valid) begin
            r_discard <= 1'b1;
            r_state   <= ST_WAIT;
         end else begin
            r_discard <= 1'b0;
            r_state   <= ST_REQ;
         end
      end else begin
         case (r_state)
            ST_REQ:  r_state <= w_not_full ? ST_WAIT : ST_HOLD;
            ST_HOLD: if (w_not_full) r_state <= ST_REQ;
            ST_WAIT: begin
               if (bus.imem_valid) begin
                  if (!r_discard) r_fetch_pc <= w_pc_plus4;
                  r_discard <= 1'b0;
                  r_state   <= ST_REQ;
               end
            end
            default: r_state <= ST_REQ;
         endcase

         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);

         if (w_pop) begin
            r_rd_ptr     <= r_rd_ptr + PTR_W'(1);
            r_ifid_valid <= 1'b1;
            r_ifid_instr <= r_fifo_instr[r_rd_ptr];
            r_ifid_pc4   <= r_fifo_pc4[r_rd_ptr];
         end else if (!bus.stall) begin
            r_ifid_valid <= 1'b0;
         end

         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: randomized memory latency, stalls and redirects,
// with the expected instruction stream kept in a scoreboard queue.
module tb_if_fetch_unit;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   if_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   if_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

   if_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(2))
      u_dut (.clk(clk), .rst(rst), .bus(bus.master));

   if_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2))
      u_dut2 (.clk(clk), .rst(rst), .bus(bus2.master));

   int errors = 0;
   int checks = 0;

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: after reset or redirect, IF/ID must see the sequential
   // word stream starting at the (aligned) start address; memory returns addr.
   logic [31:0] exp_instr[$];
   logic [31:0] exp_pc4[$];

   task automatic reset_model(input logic [31:0] start);
      logic [31:0] pc;
      exp_instr.delete();
      exp_pc4.delete();
      pc = start;
      for (int i = 0; i < 512; i++) begin
         exp_instr.push_back(pc);
         exp_pc4.push_back(pc + 32'd4);
         pc = pc + 32'd4;
      end
   endtask

   // Main memory model: variable latency, single outstanding request.
   bit          m_pend = 1'b0;
   int          m_wait = 0;
   logic [31:0] m_addr = '0;
   bit          m_dead = 1'b0;
   int          lat_max = 0;

   always @(negedge clk) begin
      bus.imem_valid = 1'b0;
      if (m_pend) begin
         if (rst) m_wait = 0;
         else if (m_wait == 0) begin
            bus.imem_valid = 1'b1;
            bus.imem_rdata = m_dead ? 32'h0000_DEAD : m_addr;
            m_dead = 1'b0;
            m_pend = 1'b0;
         end else m_wait--;
      end
      if (bus.imem_req) begin
         chk(!m_pend, "one_outstanding", 32'(m_pend), 32'd0);
         chk(bus.imem_addr[1:0] == 2'b00, "addr_align", bus.imem_addr, {bus.imem_addr[31:2], 2'b00});
         m_pend = 1'b1;
         m_addr = bus.imem_addr;
         m_wait = $urandom_range(lat_max, 0);
      end
   end

   // Second instance: zero-wait memory, no stall/redirect.
   bit          p2 = 1'b0;
   logic [31:0] a2 = '0;
   always @(negedge clk) begin
      bus2.imem_valid = p2 && !rst;
      bus2.imem_rdata = a2;
      p2 = bus2.imem_req;
      a2 = bus2.imem_addr;
   end

   // Monitor: pops the scoreboard on every new valid IF/ID instruction.
   logic [31:0] prev_instr = '0, prev_pc4 = '0;
   logic        prev_valid = 1'b0;
   logic [31:0] e_i, e_p;
   bit          s_rst, s_stall, s_redir;
   bit          dead_seen = 1'b0;
   int          idle = 0;

   always @(posedge clk) begin
      s_rst   = rst;
      s_stall = bus.stall;
      s_redir = bus.redirect;
      #1;
      if (s_rst || rst) begin
         prev_instr = '0; prev_pc4 = '0; prev_valid = 1'b0; idle = 0;
      end else begin
         if (bus.ifid_valid && bus.ifid_instr == 32'h0000_DEAD) dead_seen = 1'b1;
         if (s_redir) begin
            chk(!bus.ifid_valid, "redirect_flush", 32'(bus.ifid_valid), 32'd0);
            idle = 0;
         end else if (s_stall) begin
            chk(bus.ifid_valid == prev_valid && bus.ifid_instr == prev_instr &&
                bus.ifid_pc_plus4 == prev_pc4, "stall_hold", bus.ifid_pc_plus4, prev_pc4);
         end else if (bus.ifid_valid) begin
            idle = 0;
            if (exp_instr.size() == 0) chk(1'b0, "scoreboard_empty", bus.ifid_pc_plus4, 32'd0);
            else begin
               e_i = exp_instr.pop_front();
               e_p = exp_pc4.pop_front();
               chk(bus.ifid_instr == e_i, "ifid_instr", bus.ifid_instr, e_i);
               chk(bus.ifid_pc_plus4 == e_p, "ifid_pc_plus4", bus.ifid_pc_plus4, e_p);
            end
         end else begin
            chk(bus.ifid_instr == prev_instr && bus.ifid_pc_plus4 == prev_pc4,
                "bubble_hold", bus.ifid_pc_plus4, prev_pc4);
            idle++;
            if (idle > 40) begin
               chk(1'b0, "progress_timeout", 32'(idle), 32'd40);
               idle = 0;
            end
         end
         prev_instr = bus.ifid_instr;
         prev_pc4   = bus.ifid_pc_plus4;
         prev_valid = bus.ifid_valid;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Bounded wait for the next request; returns at the negedge it is seen.
   task automatic wait_req(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         if (bus.imem_req) seen = 1'b1;
      end
      if (!seen) chk(1'b0, name, 32'd0, 32'd1);
   endtask

   logic [31:0] pc_a, rpc;
   bit          got;

   initial begin
      rst = 1'b1;
      bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
      bus2.stall = 1'b0; bus2.redirect = 1'b0; bus2.redirect_pc = '0;
      lat_max = 0;
      reset_model(32'h0);
      repeat (3) @(posedge clk);
      #2;
      chk(!bus.ifid_valid, "rst_ifid_valid", 32'(bus.ifid_valid), 32'd0);
      chk(bus.ifid_instr == 32'd0, "rst_ifid_instr", bus.ifid_instr, 32'd0);
      chk(bus.ifid_pc_plus4 == 32'd0, "rst_ifid_pc4", bus.ifid_pc_plus4, 32'd0);
      chk(!bus.imem_req, "rst_imem_req", 32'(bus.imem_req), 32'd0);
      rst = 1'b0;

      // Zero-wait latency and PC sequence; wrap-around on the second instance.
      #1;
      chk(bus.imem_req && bus.imem_addr == 32'h0, "first_req", bus.imem_addr, 32'h0);
      chk(bus2.imem_req && bus2.imem_addr == 32'hFFFF_FFFC, "wrap_first_req", bus2.imem_addr, 32'hFFFF_FFFC);
      tick();
      tick();
      chk(bus.imem_req && bus.imem_addr == 32'h4, "second_req", bus.imem_addr, 32'h4);
      chk(bus2.imem_req && bus2.imem_addr == 32'h0, "wrap_second_req", bus2.imem_addr, 32'h0);
      tick();
      chk(bus.ifid_valid && bus.ifid_pc_plus4 == 32'h4 && bus.ifid_instr == 32'h0,
          "first_valid_edge3", bus.ifid_pc_plus4, 32'h4);
      chk(bus2.ifid_valid && bus2.ifid_pc_plus4 == 32'h0 && bus2.ifid_instr == 32'hFFFF_FFFC,
          "wrap_first_valid", bus2.ifid_pc_plus4, 32'h0);
      tick();
      chk(!bus.ifid_valid, "alternate_bubble", 32'(bus.ifid_valid), 32'd0);
      tick();
      chk(bus.ifid_valid && bus.ifid_pc_plus4 == 32'h8, "second_valid", bus.ifid_pc_plus4, 32'h8);

      // Long stall: FIFO fills, fetch parks, then two back-to-back outputs.
      bus.stall = 1'b1;
      repeat (10) tick();
      chk(!bus.imem_req, "stall_full_no_req", 32'(bus.imem_req), 32'd0);
      bus.stall = 1'b0;
      tick();
      pc_a = bus.ifid_pc_plus4;
      chk(bus.ifid_valid, "release_first", 32'(bus.ifid_valid), 32'd1);
      tick();
      chk(bus.ifid_valid && bus.ifid_pc_plus4 == pc_a + 32'd4, "release_back_to_back",
          bus.ifid_pc_plus4, pc_a + 32'd4);
      repeat (4) tick();

      // Redirect while waiting on a slow response carrying 0xDEAD.
      wait_req("t3_wait_req");
      @(posedge clk); #2;
      m_wait = 2;
      m_dead = 1'b1;
      bus.redirect = 1'b1; bus.redirect_pc = 32'h100;
      reset_model(32'h100);
      tick();
      bus.redirect = 1'b0;
      wait_req("t3_next_req");
      chk(bus.imem_addr == 32'h100, "redirect_next_addr", bus.imem_addr, 32'h100);
      repeat (10) tick();

      // Redirect to an unaligned target while stalled with a full FIFO.
      bus.stall = 1'b1;
      repeat (8) tick();
      bus.redirect = 1'b1; bus.redirect_pc = 32'h203;
      reset_model(32'h200);
      tick();
      bus.redirect = 1'b0;
      chk(!bus.ifid_valid, "redir_stall_flush", 32'(bus.ifid_valid), 32'd0);
      wait_req("t4_next_req");
      chk(bus.imem_addr == 32'h200, "redir_unaligned_addr", bus.imem_addr, 32'h200);
      repeat (3) tick();
      bus.stall = 1'b0;
      repeat (10) tick();

      // Asynchronous reset in the middle of a wait.
      lat_max = 2;
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         tick();
         if (bus.ifid_valid) got = 1'b1;
      end
      chk(got, "t6_find_valid", 32'(got), 32'd1);
      bus.stall = 1'b1;
      wait_req("t6_wait_req");
      @(posedge clk); #2;
      m_wait = 2;
      chk(bus.ifid_valid, "t6_pre_valid", 32'(bus.ifid_valid), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk(!bus.ifid_valid, "async_rst_valid", 32'(bus.ifid_valid), 32'd0);
      chk(!bus.imem_req, "async_rst_req", 32'(bus.imem_req), 32'd0);
      chk(bus.ifid_pc_plus4 == 32'd0, "async_rst_pc4", bus.ifid_pc_plus4, 32'd0);
      reset_model(32'h0);
      bus.stall = 1'b0;
      @(posedge clk);
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      chk(bus.imem_req && bus.imem_addr == 32'h0, "restart_addr", bus.imem_addr, 32'h0);
      repeat (12) tick();

      // Randomized traffic.
      lat_max = 3;
      for (int c = 0; c < 1500; c++) begin
         bus.stall = (($urandom % 4) == 0);
         if (!bus.imem_req && (($urandom % 20) == 0)) begin
            rpc = $urandom;
            if (($urandom % 4) == 0) rpc = 32'hFFFF_FFF0 | {28'd0, rpc[3:0]};
            bus.redirect = 1'b1;
            bus.redirect_pc = rpc;
            reset_model({rpc[31:2], 2'b00});
         end else begin
            bus.redirect = 1'b0;
         end
         tick();
      end
      bus.redirect = 1'b0;
      bus.stall = 1'b0;
      repeat (20) tick();

      chk(!dead_seen, "dead_never_output", 32'(dead_seen), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
